// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port data RAM among NUM_CORES load/store ports, one 3-cycle
// transaction at a time. Round-robin by default; define ARB_FIXED_PRIORITY_EN for lowest-index wins.
module ram_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   localparam int ID_W     = $clog2(NUM_CORES)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [NUM_CORES-1:0]        req_we,
   input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
   input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
   output logic [NUM_CORES-1:0]        ack,
   output logic [DATA_W-1:0]           rdata,
   output logic                        ram_we,
   output logic [ADDR_W-1:0]           ram_addr,
   output logic [DATA_W-1:0]           ram_wdata,
   input  logic [DATA_W-1:0]           ram_rdata,
   output logic                        busy,
   output logic [ID_W-1:0]             owner
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [ADDR_W-1:0] addr_arr  [NUM_CORES];
   logic [DATA_W-1:0] wdata_arr [NUM_CORES];
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   idx;

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
   end

`ifdef ARB_FIXED_PRIORITY_EN
   // Scan downwards so the lowest requesting index is the last assignment.
   always_comb begin
      winner = '0;
      idx    = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         idx = ID_W'(i);
         if (req[idx]) winner = idx;
      end
   end
`else
   logic [ID_W-1:0] last_grant_q, last_grant_d;
   logic            found;

   // Search starts one past the previous winner so every requester is reached in turn.
   always_comb begin
      winner = '0;
      idx    = '0;
      found  = 1'b0;
      for (int k = 1; k <= NUM_CORES; k++) begin
         idx = ID_W'((int'(last_grant_q) + k) % NUM_CORES);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == StIdle && |req) last_grant_d = winner;
   end

   always_ff @(posedge clk) begin
      if (rst) last_grant_q <= ID_W'(NUM_CORES - 1);
      else     last_grant_q <= last_grant_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               state_d = StAccess;
               owner_d = winner;
               we_d    = req_we[winner];
               addr_d  = addr_arr[winner];
               wdata_d = wdata_arr[winner];
            end
         end
         StAccess: begin
            state_d = StResp;
            rdata_d = ram_rdata;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         owner_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      ack = '0;
      if (state_q == StResp) ack[owner_q] = 1'b1;
   end

   assign ram_we    = (state_q == StAccess) && we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign rdata     = rdata_q;
   assign busy      = (state_q != StIdle);
   assign owner     = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 1 KB behavioural RAM; covers both priority builds.
module tb_ram_arbiter;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N-1:0]    req_we = '0;
   logic [N*32-1:0] req_addr = '0;
   logic [N*32-1:0] req_wdata = '0;
   logic [N-1:0]    ack;
   logic [31:0]     rdata;
   logic            ram_we;
   logic [31:0]     ram_addr;
   logic [31:0]     ram_wdata;
   logic [31:0]     ram_rdata;
   logic            busy;
   logic [1:0]      owner;

   int n_tests = 0;
   int n_fail  = 0;
   int ack_cnt [N];
   int c0, c1, c2;

   logic [31:0] mem [256];

   ram_arbiter #(.NUM_CORES(N), .ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .ack       (ack),
      .rdata     (rdata),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .busy      (busy),
      .owner     (owner)
   );

   always #5 clk = ~clk;

   // RAM reloads a known pattern on reset; a write on the same edge still lands last.
   assign ram_rdata = mem[ram_addr[9:2]];
   always @(posedge clk) begin
      if (rst) for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
   end

   initial for (int i = 0; i < N; i++) ack_cnt[i] = 0;
   always @(negedge clk) for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic on, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
      req[i]              = on;
      req_we[i]           = we;
      req_addr[i*32 +: 32]  = a;
      req_wdata[i*32 +: 32] = d;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_ack", 64'(ack), 64'h0);
      check_eq("rst_busy", 64'(busy), 64'h0);
      check_eq("rst_ram_we", 64'(ram_we), 64'h0);
      check_eq("rst_owner", 64'(owner), 64'h0);
      check_eq("rst_rdata", 64'(rdata), 64'h0);

      // Core 2 store then load back
      drive(2, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
      tick();
      check_eq("st_ram_we", 64'(ram_we), 64'h1);
      check_eq("st_ram_addr", 64'(ram_addr), 64'h40);
      check_eq("st_ram_wdata", 64'(ram_wdata), 64'hDEAD_BEEF);
      check_eq("st_owner", 64'(owner), 64'h2);
      check_eq("st_ack_early", 64'(ack), 64'h0);
      tick();
      check_eq("st_ack", 64'(ack), 64'h4);
      check_eq("st_ram_we_off", 64'(ram_we), 64'h0);
      check_eq("st_ram_addr_hold", 64'(ram_addr), 64'h40);
      drive(2, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
      tick();
      check_eq("st_idle_ack", 64'(ack), 64'h0);
      check_eq("st_idle_busy", 64'(busy), 64'h0);
      drive(2, 1'b1, 1'b0, 32'h40, 32'h0);
      tick();
      check_eq("ld_ram_we", 64'(ram_we), 64'h0);
      tick();
      check_eq("ld_ack", 64'(ack), 64'h4);
      check_eq("ld_rdata", 64'(rdata), 64'hDEAD_BEEF);
      drive(2, 1'b0, 1'b0, 32'h40, 32'h0);
      tick();

      // All four cores load continuously from reset
      rst = 1'b1;
      for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      for (int t = 0; t < 12; t++) begin
         check_eq("rr_owner", 64'(owner), 64'(t % 4));
         check_eq("rr_busy", 64'(busy), 64'h1);
         check_eq("rr_ack_access", 64'(ack), 64'h0);
         tick();
         check_eq("rr_ack", 64'(ack), 64'(1 << (t % 4)));
         check_eq("rr_rdata", 64'(rdata), 64'(32'hA000_0040 + 32'(t % 4)));
         tick();
         check_eq("rr_ack_idle", 64'(ack), 64'h0);
         tick();
      end
      for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();

      // Cores 1 and 3 together with last_grant = 1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1, 1'b1, 1'b0, 32'h104, 32'h0);
      tick();
      check_eq("pre_owner1", 64'(owner), 64'h1);
      tick();
      drive(3, 1'b1, 1'b0, 32'h10C, 32'h0);
      tick();
      tick();
      check_eq("pair_first", 64'(owner), 64'h3);
      tick();
      check_eq("pair_ack3", 64'(ack), 64'h8);
      check_eq("pair_rdata3", 64'(rdata), 64'hA000_0043);
      drive(3, 1'b0, 1'b0, 32'h10C, 32'h0);
      tick();
      tick();
      check_eq("pair_second", 64'(owner), 64'h1);
      tick();
      check_eq("pair_ack1", 64'(ack), 64'h2);
      check_eq("pair_rdata1", 64'(rdata), 64'hA000_0041);
      drive(1, 1'b0, 1'b0, 32'h104, 32'h0);
      tick();

      // Core 0 holds req one cycle past ack: double access
      c0 = ack_cnt[0];
      drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
      tick();
      tick();
      check_eq("hold_ack", 64'(ack), 64'h1);
      tick();
      check_eq("hold_idle_busy", 64'(busy), 64'h0);
      tick();
      check_eq("hold_regrant_busy", 64'(busy), 64'h1);
      check_eq("hold_regrant_owner", 64'(owner), 64'h0);
      drive(0, 1'b0, 1'b0, 32'h100, 32'h0);
      tick();
      tick();
      tick();
      check_eq("hold_two_acks", 64'(ack_cnt[0] - c0), 64'h2);
      c0 = ack_cnt[0];
      drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
      tick();
      tick();
      drive(0, 1'b0, 1'b0, 32'h100, 32'h0);
      tick();
      tick();
      tick();
      check_eq("drop_busy", 64'(busy), 64'h0);
      check_eq("drop_one_ack", 64'(ack_cnt[0] - c0), 64'h1);

      // Reset during a core 1 store
      c1 = ack_cnt[1];
      drive(1, 1'b1, 1'b1, 32'h80, 32'h55AA_1234);
      tick();
      check_eq("rsta_ram_we", 64'(ram_we), 64'h1);
      check_eq("rsta_owner", 64'(owner), 64'h1);
      rst = 1'b1;
      tick();
      check_eq("rsta_busy", 64'(busy), 64'h0);
      check_eq("rsta_ram_we_off", 64'(ram_we), 64'h0);
      check_eq("rsta_ack", 64'(ack), 64'h0);
      check_eq("rsta_owner0", 64'(owner), 64'h0);
      check_eq("rsta_rdata", 64'(rdata), 64'h0);
      check_eq("rsta_commit", 64'(mem[8'h20]), 64'h55AA_1234);
      rst = 1'b0;
      drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
      tick();
      check_eq("rsta_next_owner", 64'(owner), 64'h0);
      check_eq("rsta_no_ack1", 64'(ack_cnt[1] - c1), 64'h0);
      tick();
      check_eq("rsta_ack0", 64'(ack), 64'h1);
      drive(0, 1'b0, 1'b0, 32'h100, 32'h0);
      tick();
      tick();
      check_eq("rsta_then1", 64'(owner), 64'h1);
      tick();
      check_eq("rsta_ack1", 64'(ack), 64'h2);
      drive(1, 1'b0, 1'b0, 32'h80, 32'h0);
      tick();

      // Cores 0 and 2 request continuously
      rst = 1'b1;
      tick();
      rst = 1'b0;
      c2 = ack_cnt[2];
      drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
      drive(2, 1'b1, 1'b0, 32'h108, 32'h0);
      for (int t = 0; t < 4; t++) begin
         tick();
`ifdef ARB_FIXED_PRIORITY_EN
         check_eq("fix_owner", 64'(owner), 64'h0);
`else
         check_eq("alt_owner", 64'(owner), 64'((t % 2) * 2));
`endif
         tick();
         tick();
      end
`ifdef ARB_FIXED_PRIORITY_EN
      check_eq("fix_no_ack2", 64'(ack_cnt[2] - c2), 64'h0);
`else
      check_eq("alt_ack2", 64'(ack_cnt[2] - c2), 64'h2);
`endif
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Round-robin arbiter sharing the single-port 1 KB data RAM between the quad-core cluster's load/store ports.
- Each core raises a request. The arbiter selects one winner, registers its command, and drives the RAM for one access cycle. It then returns an ack pulse with read data.
- Sits between the core LSUs and data_ram. It is the only master of the RAM's we/addr/wdata.

Parameters:
- NUM_CORES, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- (localparam) ID_W, $clog2(NUM_CORES), owner index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_CORES  per-core request; held until ack
- req_we  in  NUM_CORES  per-core write enable (1=store, 0=load)
- req_addr  in  NUM_CORES*ADDR_W  per-core byte address; core i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CORES*DATA_W  per-core store data, same packing
- ack  out  NUM_CORES  one-hot, 1-cycle completion pulse
- rdata  out  DATA_W  load data; valid only in the ack cycle, shared by all cores
- ram_we  out  1  to RAM write enable
- ram_addr  out  ADDR_W  to RAM address
- ram_wdata  out  DATA_W  to RAM write data
- ram_rdata  in  DATA_W  from RAM asynchronous read data
- busy  out  1  high in ACCESS and RESP
- owner  out  ID_W  index of core being served; valid while busy

Behaviour:
- FSM states and transitions:
  - IDLE -> ACCESS when any req bit is set; otherwise stays in IDLE.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
  - One transaction costs exactly 3 cycles. Peak throughput is 1 access per 3 cycles.
- IDLE, with any req set:
  - Selects a winner and latches owner, we_q, addr_q and wdata_q from the winner's inputs.
  - Updates last_grant to the winner.
- ACCESS:
  - ram_we = we_q, ram_addr = addr_q, ram_wdata = wdata_q.
  - A store commits to RAM on the rising edge that ends ACCESS.
  - On that same edge, rdata_q <= ram_rdata (captured for loads and stores alike).
- RESP:
  - ack[owner] = 1 and rdata = rdata_q.
  - req inputs are ignored, so the just-served core, whose req is still high, cannot be re-granted.
- Outside ACCESS:
  - ram_we = 0.
  - ram_addr and ram_wdata hold addr_q and wdata_q (no toggling).
- Round-robin selection:
  - The search starts at (last_grant+1) mod NUM_CORES; the first set req bit wins.
  - Reset sets last_grant = NUM_CORES-1, so core 0 wins first.
  - A continuously requesting core waits at most NUM_CORES-1 other grants.
- Latency: req seen in IDLE at edge N -> ack high in cycle N+2.
- Request rules:
  - req_we, req_addr and req_wdata must be stable while req is high.
  - A core dropping req after winning does not abort the transaction; the ack pulse is still issued.
  - A core must deassert req the cycle after ack, or it re-enters arbitration.
- Addresses pass through unmodified. Alignment and range checking are not performed here.
- ack, busy, ram_we and rdata are registered-state decodes, free of combinational paths from req.
- Reset (any state, including mid-ACCESS):
  - Next cycle: state=IDLE, ack=0, ram_we=0, busy=0, owner=0, rdata=0, last_grant=NUM_CORES-1.
  - No ack is issued for the abandoned transaction.
  - A store in ACCESS in the same cycle rst is asserted still commits on that edge. rst takes effect afterwards.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority; the lowest-index requesting core always wins. last_grant is unused.
- Undefined (default): round-robin as above.
- Ports and timing are identical in both builds.

Test Plan:
- Reset, then core 2 stores 0xDEADBEEF to 0x40. Required:
  - ram_we=1 for exactly one cycle with ram_addr=0x40.
  - ack=4'b0100 two cycles after req.
  - A later core 2 load of 0x40 returns rdata=0xDEADBEEF in its ack cycle.
- All four cores request loads continuously from reset. Required:
  - Grant order 0,1,2,3,0,1...
  - Exactly one ack bit per 3 cycles.
  - No core is granted twice before the others.
- Cores 1 and 3 request simultaneously with last_grant=1. Required: core 3 is served first, then core 1.
- Core 0 holds req for one cycle after its ack with no other requesters. Required: a second core-0 grant follows (double access). Confirms the one-cycle deassert rule. The normal drop after ack produces one ack only.
- rst asserted during ACCESS of a core 1 store. Required:
  - No ack[1].
  - State IDLE, ram_we=0 and busy=0 the next cycle.
  - The next grant goes to core 0 when cores 0 and 1 both request.
- With ARB_FIXED_PRIORITY_EN defined, cores 0 and 2 request continuously. Required: core 0 wins every arbitration; core 2 is never acked.
